dp_aux_sink_responder: RTL
==========================

Name: dp_aux_sink_responder

Overview:
- Sink-side (responder) end of the AUX request/reply transaction path.
- Accepts decoded AUX request transactions (command, address, length, write bytes) and services native DPCD reads and writes against an internal byte-wide register file.
- Returns an ACK/NACK/DEFER reply and, for reads, a byte stream of read data.
- Serves as the synthesizable sink model that the transaction-layer initiator talks to.

Parameters:
AUX_ADDRESS_WIDTH, 20, request address width
AUX_DATA_WIDTH, 8, data byte width
DPCD_DEPTH, 1024, implemented DPCD bytes, addresses 0..DPCD_DEPTH-1
RO_LIMIT, 256, addresses below this are read-only capability registers
MAX_LEN, 16, maximum bytes per transaction
REPLY_DELAY, 4, turnaround cycles between request end and reply (>=1)
MAX_LINK_RATE, 8'h14, reset value of DPCD 0x001
MAX_LANE_COUNT, 8'h84, reset value of DPCD 0x002

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
REQ_VLD  in  1  request header valid
REQ_RDY  out  1  responder can accept a header
REQ_CMD  in  4  AUX command: 1000 native write, 1001 native read, 0xxx I2C
REQ_ADDR  in  AUX_ADDRESS_WIDTH  start address
REQ_LEN  in  AUX_DATA_WIDTH  byte count minus one
REQ_DATA  in  AUX_DATA_WIDTH  write byte
REQ_DATA_VLD  in  1  write byte valid
SINK_BUSY  in  1  forces DEFER when sampled high at header acceptance
RPL_ACK  out  2  00 ACK, 01 NACK, 10 DEFER
RPL_ACK_VLD  out  1  one-cycle reply status strobe
RPL_DATA  out  AUX_DATA_WIDTH  read byte
RPL_DATA_VLD  out  1  read byte valid
RPL_NATIVE_I2C  out  1  REQ_CMD[3] of the transaction being replied

Behaviour:
- Reset (rst=1 at posedge): state IDLE; REQ_RDY=1 on the following cycle; all other outputs 0. Register file all zero except [0x000]=8'h12, [0x001]=MAX_LINK_RATE, [0x002]=MAX_LANE_COUNT. Reset mid-transaction aborts it: no reply is issued, and partial writes are lost because the register file is reset.
- Accept: in IDLE with REQ_VLD=1, latch CMD, ADDR, LEN and SINK_BUSY. Compute the verdict in a 21-bit sum with no wrap:
  - DEFER if SINK_BUSY=1.
  - Else NACK if CMD[3]=0 (no I2C slave), CMD not 1000/1001, LEN+1>MAX_LEN, or ADDR+LEN>=DPCD_DEPTH.
  - Else ACK.
- States: IDLE -> WR_DATA (CMD=1000) or WAIT (all other commands) -> REPLY -> RD_DATA (ACK read only) -> IDLE.
- REQ_RDY=1 only in IDLE. REQ_VLD outside IDLE is ignored.
- WR_DATA:
  - Consumes exactly LEN+1 REQ_DATA_VLD beats; gaps are allowed.
  - On verdict ACK, beat k writes ADDR+k in the same cycle, unless ADDR+k<RO_LIMIT (silently dropped, still ACK).
  - On NACK or DEFER, beats are consumed and discarded.
  - After the last beat -> WAIT.
  - REQ_DATA_VLD in any other state is ignored.
- WAIT: counts REPLY_DELAY cycles -> REPLY.
- REPLY: one cycle with RPL_ACK_VLD=1, RPL_ACK=verdict, RPL_NATIVE_I2C=latched CMD[3].
  - ACK read -> RD_DATA.
  - Any other case -> IDLE.
- RD_DATA:
  - LEN+1 consecutive cycles with RPL_DATA_VLD=1 and RPL_DATA=mem[ADDR+k], k=0..LEN; no gaps.
  - Read data reflects writes committed before the header was accepted.
  - Then -> IDLE.
- Latency, read: header accepted at cycle T -> RPL_ACK_VLD at T+1+REPLY_DELAY -> first data at T+2+REPLY_DELAY.
- Latency, write: last data beat at cycle W -> RPL_ACK_VLD at W+1+REPLY_DELAY.
- RPL_ACK, RPL_DATA and RPL_NATIVE_I2C return to 0 whenever their valid is low.
- Boundaries:
  - ADDR=DPCD_DEPTH-1 with LEN=0 -> ACK.
  - LEN=MAX_LEN-1 -> ACK.
  - LEN=MAX_LEN -> NACK.
  - SINK_BUSY changing after acceptance has no effect.

Test Plan:
- Reset, then native read ADDR=0x000 LEN=2 -> REQ_RDY falls, RPL_ACK_VLD at T+5 with ACK, then bytes 12,14,84 on three consecutive cycles.
- Native write ADDR=0x100 LEN=3 with data 11,22,33,44 and a 2-cycle gap after byte 2 -> ACK 5 cycles after last beat; read 0x100 LEN=3 returns 11,22,33,44.
- Write 0x000 data AA -> ACK; read 0x000 returns 12 (read-only preserved).
- Read ADDR=0x3FF LEN=1 -> NACK, no data beats; read LEN=16 -> NACK; I2C read CMD=0001 -> NACK with RPL_NATIVE_I2C=0.
- SINK_BUSY=1 at write header to 0x200 with data 55 -> DEFER; read 0x200 returns 00.
- Reset asserted during RD_DATA after byte 1 -> RPL_DATA_VLD=0 next cycle, REQ_RDY=1, no further reply; earlier RW writes read back as 00.

Source files
------------

// File: rtl/dp_aux_sink_responder.sv
// dp_aux_sink_responder: AUX sink that answers native DPCD reads/writes from a local register file
module dp_aux_sink_responder #(
  parameter int AUX_ADDRESS_WIDTH = 20,
  parameter int AUX_DATA_WIDTH = 8,
  parameter int DPCD_DEPTH = 1024,
  parameter int RO_LIMIT = 256,
  parameter int MAX_LEN = 16,
  parameter int REPLY_DELAY = 4,
  parameter logic [7:0] MAX_LINK_RATE = 8'h14,
  parameter logic [7:0] MAX_LANE_COUNT = 8'h84
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         REQ_VLD,
  output logic                         REQ_RDY,
  input  logic [3:0]                   REQ_CMD,
  input  logic [AUX_ADDRESS_WIDTH-1:0] REQ_ADDR,
  input  logic [AUX_DATA_WIDTH-1:0]    REQ_LEN,
  input  logic [AUX_DATA_WIDTH-1:0]    REQ_DATA,
  input  logic                         REQ_DATA_VLD,
  input  logic                         SINK_BUSY,
  output logic [1:0]                   RPL_ACK,
  output logic                         RPL_ACK_VLD,
  output logic [AUX_DATA_WIDTH-1:0]    RPL_DATA,
  output logic                         RPL_DATA_VLD,
  output logic                         RPL_NATIVE_I2C
);
  localparam int SW = AUX_ADDRESS_WIDTH + 1;
  localparam int AW = $clog2(DPCD_DEPTH);
  localparam int CW = 16;
  typedef enum logic [2:0] {IDLE, WR_DATA, WAIT, REPLY, RD_DATA} state_t;
  state_t state;
  logic [3:0] cmd;
  logic [AUX_ADDRESS_WIDTH-1:0] addr;
  logic [AUX_DATA_WIDTH-1:0] len;
  logic [1:0] verdict, verdict_in;
  logic [CW-1:0] cnt;
  logic [SW-1:0] sum, ptr;
  logic we;
  logic [AUX_DATA_WIDTH-1:0] mem [DPCD_DEPTH];
  // the range check uses one extra bit so addresses near the top never wrap into range
  always_comb begin
    sum = {1'b0, REQ_ADDR} + SW'(REQ_LEN);
    ptr = {1'b0, addr} + SW'(cnt);
    verdict_in = SINK_BUSY ? 2'b10 :
                 (REQ_CMD[3:1] != 3'b100 || int'(REQ_LEN) >= MAX_LEN || sum >= SW'(DPCD_DEPTH)) ? 2'b01 : 2'b00;
    we = state == WR_DATA && REQ_DATA_VLD && verdict == 2'b00 && ptr >= SW'(RO_LIMIT);
  end
  assign REQ_RDY = state == IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cmd <= '0;
      addr <= '0;
      len <= '0;
      verdict <= '0;
      cnt <= '0;
      RPL_ACK <= '0;
      RPL_ACK_VLD <= 1'b0;
      RPL_DATA <= '0;
      RPL_DATA_VLD <= 1'b0;
      RPL_NATIVE_I2C <= 1'b0;
    end else begin
      RPL_ACK <= '0;
      RPL_ACK_VLD <= 1'b0;
      RPL_DATA <= '0;
      RPL_DATA_VLD <= 1'b0;
      RPL_NATIVE_I2C <= 1'b0;
      case (state)
        IDLE: if (REQ_VLD) begin
          cmd <= REQ_CMD;
          addr <= REQ_ADDR;
          len <= REQ_LEN;
          verdict <= verdict_in;
          cnt <= '0;
          state <= REQ_CMD == 4'b1000 ? WR_DATA : WAIT;
        end
        WR_DATA: if (REQ_DATA_VLD) begin
          cnt <= cnt == CW'(len) ? '0 : cnt + 1'b1;
          state <= cnt == CW'(len) ? WAIT : WR_DATA;
        end
        WAIT: if (cnt == CW'(REPLY_DELAY)) begin
          cnt <= '0;
          state <= REPLY;
          RPL_ACK_VLD <= 1'b1;
          RPL_ACK <= verdict;
          RPL_NATIVE_I2C <= cmd[3];
        end else cnt <= cnt + 1'b1;
        // first read byte leaves together with the exit from REPLY so the stream has no gap
        REPLY: if (verdict == 2'b00 && cmd == 4'b1001) begin
          state <= RD_DATA;
          RPL_DATA_VLD <= 1'b1;
          RPL_DATA <= mem[ptr[AW-1:0]];
          cnt <= 1;
        end else state <= IDLE;
        RD_DATA: if (cnt == CW'(len) + CW'(1)) state <= IDLE;
        else begin
          RPL_DATA_VLD <= 1'b1;
          RPL_DATA <= mem[ptr[AW-1:0]];
          cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DPCD_DEPTH; i++) mem[i] <= '0;
      mem[0] <= AUX_DATA_WIDTH'(8'h12);
      mem[1] <= AUX_DATA_WIDTH'(MAX_LINK_RATE);
      mem[2] <= AUX_DATA_WIDTH'(MAX_LANE_COUNT);
    end else if (we) mem[ptr[AW-1:0]] <= REQ_DATA;
  end
endmodule
